// File: rtl/tk1_spi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tk1_spi_flash_reader
//  Purpose  : Converts one read request (24-bit address, 1..256 bytes) into a
//             full SPI flash READ transaction on the tk1 SPI byte master:
//             select, opcode, 3 address bytes, N data bytes, deselect.
//             Received data bytes are queued in a small output FIFO.
//  Options  : TK1_SPI_READER_FAST_READ_EN - use the fast-read opcode and
//             insert one discarded dummy byte after the address.
//  Revision : 1.0 - initial release
// ============================================================================
module tk1_spi_flash_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter logic [7:0]  CMD_FREAD  = 8'h0b
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic [23:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        spi_enable,
  output logic        spi_enable_we,
  output logic        spi_start,
  output logic [7:0]  spi_tx_data,
  output logic        spi_tx_data_we,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_ready
);

  localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef TK1_SPI_READER_FAST_READ_EN
  // Opcode + 3 address bytes + 1 dummy byte.
  localparam bit         FAST_READ = 1'b1;
  localparam logic [2:0] HDR_LEN   = 3'd5;
`else
  // Opcode + 3 address bytes.
  localparam bit         FAST_READ = 1'b0;
  localparam logic [2:0] HDR_LEN   = 3'd4;
`endif
  localparam logic [7:0] OPCODE = FAST_READ ? CMD_FREAD : CMD_READ;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_LOAD    = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_CAPTURE = 3'd5,
    S_DESEL   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        wait_first_q, wait_first_d;
  logic [2:0]  idx_q, idx_d;          // byte index; saturates at HDR_LEN in data phase
  logic [23:0] addr_q, addr_d;
  logic [8:0]  rem_q, rem_d;          // data bytes still to be captured

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        spi_enable_q, spi_enable_d;
  logic        spi_enable_we_q, spi_enable_we_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_tx_data_q, spi_tx_data_d;
  logic        spi_tx_data_we_q, spi_tx_data_we_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       in_data_phase;
  logic       fifo_push;
  logic       fifo_pop;
  logic       load_ok;
  logic [7:0] next_tx_byte;

  assign in_data_phase = (idx_q == HDR_LEN);
  assign fifo_push     = (state_q == S_CAPTURE) && in_data_phase;
  assign fifo_pop      = (cnt_q != '0) && rd_ready;

  // FIFO next state: storage write, pointer wrap and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = spi_rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Sequencer next state: request latch, byte indexing and remaining count.
  always_comb begin
    state_d      = state_q;
    wait_first_d = wait_first_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start && (cmd_len != 9'd0) && spi_ready) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          idx_d   = 3'd0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: state_d = S_LOAD;
      S_LOAD: begin
        // The load strobe is only raised once there is room for the byte.
        if (spi_tx_data_we_q) state_d = S_START;
      end
      S_START: begin
        state_d      = S_WAIT;
        wait_first_d = 1'b1;
      end
      S_WAIT: begin
        // spi_ready is still stale in the first cycle after the start pulse.
        wait_first_d = 1'b0;
        if (!wait_first_q && spi_ready) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!in_data_phase) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end else if (rem_q == 9'd1) begin
          rem_d   = 9'd0;
          state_d = S_DESEL;
        end else begin
          rem_d   = rem_q - 9'd1;
          state_d = S_LOAD;
        end
      end
      S_DESEL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte to transmit for the upcoming LOAD, selected by byte index.
  always_comb begin
    case (idx_d)
      3'd0:    next_tx_byte = OPCODE;
      3'd1:    next_tx_byte = addr_q[23:16];
      3'd2:    next_tx_byte = addr_q[15:8];
      3'd3:    next_tx_byte = addr_q[7:0];
      default: next_tx_byte = 8'h00;   // dummy byte and data-phase filler
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    load_ok          = (idx_d != HDR_LEN) || (cnt_d != FULL_CNT);
    busy_d           = (state_d != S_IDLE) && (state_d != S_DESEL);
    done_d           = (state_d == S_DESEL);
    spi_enable_we_d  = (state_d == S_SELECT) || (state_d == S_DESEL);
    spi_enable_d     = spi_enable_q;
    if (state_d == S_SELECT) spi_enable_d = 1'b1;
    if (state_d == S_DESEL)  spi_enable_d = 1'b0;
    spi_start_d      = (state_d == S_START);
    spi_tx_data_we_d = (state_d == S_LOAD) && load_ok;
    spi_tx_data_d    = (state_d == S_LOAD) ? next_tx_byte : spi_tx_data_q;
  end

  // State, FIFO and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      wait_first_q     <= 1'b0;
      idx_q            <= 3'd0;
      addr_q           <= 24'd0;
      rem_q            <= 9'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      spi_enable_q     <= 1'b0;
      spi_enable_we_q  <= 1'b0;
      spi_start_q      <= 1'b0;
      spi_tx_data_q    <= 8'h00;
      spi_tx_data_we_q <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
    end else begin
      state_q          <= state_d;
      wait_first_q     <= wait_first_d;
      idx_q            <= idx_d;
      addr_q           <= addr_d;
      rem_q            <= rem_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      spi_enable_q     <= spi_enable_d;
      spi_enable_we_q  <= spi_enable_we_d;
      spi_start_q      <= spi_start_d;
      spi_tx_data_q    <= spi_tx_data_d;
      spi_tx_data_we_q <= spi_tx_data_we_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      mem_q            <= mem_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign rd_valid       = (cnt_q != '0);
  assign rd_data        = mem_q[rd_ptr_q];
  assign spi_enable     = spi_enable_q;
  assign spi_enable_we  = spi_enable_we_q;
  assign spi_start      = spi_start_q;
  assign spi_tx_data    = spi_tx_data_q;
  assign spi_tx_data_we = spi_tx_data_we_q;

endmodule
`default_nettype wire

// File: tb/tb_tk1_spi_flash_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tk1_spi_flash_reader
//  Purpose  : Directed self-checking bench for tk1_spi_flash_reader with a
//             behavioural SPI byte master that returns a known MISO sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tk1_spi_flash_reader;

`ifdef TK1_SPI_READER_FAST_READ_EN
  localparam int         HDR = 5;
  localparam logic [7:0] OPC = 8'h0b;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        busy, done, rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        spi_enable, spi_enable_we, spi_start, spi_tx_data_we;
  logic [7:0]  spi_tx_data;
  logic [7:0]  spi_rx_data = 8'h00;
  logic        spi_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  tk1_spi_flash_reader dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .spi_enable(spi_enable), .spi_enable_we(spi_enable_we),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data),
    .spi_tx_data_we(spi_tx_data_we), .spi_rx_data(spi_rx_data),
    .spi_ready(spi_ready)
  );

  always #5 clk = ~clk;

  // Byte master model and bus monitor. Exchange n returns MISO byte 8'h5A+n.
  logic [7:0] model_tx = 8'h00;
  int         xfer_n = 0;
  int         cur_id = 0;
  int         phase = 0;
  int         ctr = 0;
  int         done_cnt = 0, we_cnt = 0, start_cnt = 0;
  logic [7:0] tx_log[$];
  logic [7:0] pop_log[$];
  logic       ss_log[$];

  always @(posedge clk) begin
    if (!reset_n) begin
      spi_ready <= 1'b1;
      phase     <= 0;
    end else begin
      if (spi_tx_data_we) begin model_tx <= spi_tx_data; we_cnt++; end
      if (spi_enable_we) ss_log.push_back(spi_enable);
      if (done) done_cnt++;
      if (rd_valid && rd_ready) pop_log.push_back(rd_data);
      if (spi_start) begin
        tx_log.push_back(model_tx);
        cur_id <= xfer_n;
        xfer_n++;
        start_cnt++;
        phase <= 1;
      end else if (phase == 1) begin
        spi_ready <= 1'b0;
        ctr       <= 2;
        phase     <= 2;
      end else if (phase == 2) begin
        if (ctr == 0) begin
          spi_ready   <= 1'b1;
          spi_rx_data <= 8'h5A + 8'(cur_id);
          phase       <= 0;
        end else begin
          ctr <= ctr - 1;
        end
      end
    end
  end

  task automatic clear_logs();
    tx_log.delete(); pop_log.delete(); ss_log.delete();
    done_cnt = 0; we_cnt = 0; start_cnt = 0;
  endtask

  task automatic issue(input logic [23:0] a, input logic [8:0] l);
    cmd_addr = a; cmd_len = l; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    obs = {busy, done, rd_valid, spi_enable, spi_enable_we, spi_start,
           spi_tx_data_we, rd_data, spi_tx_data};
    checks++;
    if (obs !== 23'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 000000", obs);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release_idle: busy=%b rd_valid=%b expected 0 0", busy, rd_valid);
    end
  endtask

  task automatic test_single_read();
    logic [7:0] exp_tx[$];
    int base, lat;
    clear_logs(); rd_ready = 1'b1; base = xfer_n;
    exp_tx = '{OPC, 8'h01, 8'h23, 8'h45};
    if (HDR == 5) exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    issue(24'h012345, 9'd1);
    lat = 1;
    while (spi_start !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL start_latency: got %0d expected 3", lat); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_during: got %b expected 1", busy); end
    wait_done(500);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after: got %b expected 0", busy); end
    checks++;
    if (tx_log != exp_tx) begin
      failures++; $display("FAIL single_tx_bytes: got %p expected %p", tx_log, exp_tx);
    end
    checks++;
    if (ss_log.size() != 2 || ss_log[0] !== 1'b1 || ss_log[1] !== 1'b0) begin
      failures++; $display("FAIL single_ss_seq: got %p expected '{1,0}", ss_log);
    end
    checks++;
    if (pop_log.size() != 1 || pop_log[0] !== 8'h5A + 8'(base + HDR)) begin
      failures++; $display("FAIL single_rd_byte: got %p expected %h", pop_log, 8'h5A + 8'(base + HDR));
    end
  endtask

  task automatic test_ignore();
    clear_logs(); rd_ready = 1'b1;
    issue(24'h000010, 9'd2);
    @(negedge clk);
    issue(24'h777777, 9'd5);   // while busy
    wait_done(1000);
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt != 1 || tx_log.size() != HDR + 2) begin
      failures++; $display("FAIL busy_start_ignored: done=%0d tx=%0d expected 1 %0d", done_cnt, tx_log.size(), HDR + 2);
    end
    clear_logs();
    issue(24'h000020, 9'd0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy: got %b expected 0", busy); end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != 0 || start_cnt != 0 || ss_log.size() != 0) begin
      failures++; $display("FAIL len0_ignored: done=%0d starts=%0d ss=%0d expected 0 0 0", done_cnt, start_cnt, ss_log.size());
    end
  endtask

  task automatic test_two_byte();
    logic [7:0] exp_tx[$];
    int base;
    clear_logs(); rd_ready = 1'b1; base = xfer_n;
    exp_tx = '{OPC, 8'hAB, 8'hCD, 8'hEF};
    if (HDR == 5) exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    issue(24'hABCDEF, 9'd2);
    wait_done(1000);
    repeat (5) @(negedge clk);
    checks++;
    if (tx_log != exp_tx) begin
      failures++; $display("FAIL two_tx_bytes: got %p expected %p", tx_log, exp_tx);
    end
    checks++;
    if (pop_log.size() != 2 || pop_log[0] !== 8'h5A + 8'(base + HDR) ||
        pop_log[1] !== 8'h5A + 8'(base + HDR + 1)) begin
      failures++; $display("FAIL two_rd_bytes: got %p expected %h %h", pop_log,
                           8'h5A + 8'(base + HDR), 8'h5A + 8'(base + HDR + 1));
    end
  endtask

  task automatic test_backpressure();
    int base, t, bad, first_bad;
    clear_logs(); rd_ready = 1'b0; base = xfer_n;
    issue(24'h100000, 9'd256);
    t = 0;
    while (start_cnt < HDR + 4 && t < 2000) begin @(negedge clk); t++; end
    repeat (60) @(negedge clk);
    checks++;
    if (start_cnt != HDR + 4 || we_cnt != HDR + 4) begin
      failures++; $display("FAIL full_stall: starts=%0d loads=%0d expected %0d", start_cnt, we_cnt, HDR + 4);
    end
    checks++;
    if (rd_valid !== 1'b1 || busy !== 1'b1 || rd_data !== 8'h5A + 8'(base + HDR)) begin
      failures++; $display("FAIL full_head: valid=%b busy=%b data=%h expected 1 1 %h",
                           rd_valid, busy, rd_data, 8'h5A + 8'(base + HDR));
    end
    rd_ready = 1'b1;
    wait_done(20000);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 1 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL long_done: done=%0d valid=%b expected 1 0", done_cnt, rd_valid);
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < pop_log.size(); i++) begin
      if (pop_log[i] !== 8'h5A + 8'(base + HDR + i)) begin
        bad++; if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (pop_log.size() != 256 || bad != 0) begin
      failures++; $display("FAIL long_order: count=%0d bad=%0d first_bad=%0d expected 256 0 -1", pop_log.size(), bad, first_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] obs;
    int base, t;
    clear_logs(); rd_ready = 1'b0;
    issue(24'h000200, 9'd8);
    t = 0;
    while ((start_cnt < HDR + 2 || rd_valid !== 1'b1) && t < 1000) begin @(negedge clk); t++; end
    reset_n = 1'b0;
    @(negedge clk);
    obs = {busy, done, rd_valid, spi_enable, spi_enable_we, spi_start,
           spi_tx_data_we, rd_data, spi_tx_data};
    checks++;
    if (obs !== 23'd0) begin
      failures++; $display("FAIL midreset_outputs: got %h expected 000000", obs);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ss_log.size() != 1 || done_cnt != 0) begin
      failures++; $display("FAIL midreset_no_desel: ss=%0d done=%0d expected 1 0", ss_log.size(), done_cnt);
    end
    clear_logs(); rd_ready = 1'b1; base = xfer_n;
    issue(24'h000300, 9'd2);
    wait_done(1000);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 1 || pop_log.size() != 2 || pop_log[0] !== 8'h5A + 8'(base + HDR) ||
        pop_log[1] !== 8'h5A + 8'(base + HDR + 1)) begin
      failures++; $display("FAIL after_reset_read: done=%0d got %p expected %h %h", done_cnt, pop_log,
                           8'h5A + 8'(base + HDR), 8'h5A + 8'(base + HDR + 1));
    end
    checks++;
    if (ss_log.size() != 2 || ss_log[0] !== 1'b1 || ss_log[1] !== 1'b0) begin
      failures++; $display("FAIL after_reset_ss: got %p expected '{1,0}", ss_log);
    end
  endtask

  initial begin
    reset_n = 1'b0; cmd_start = 1'b0; cmd_addr = 24'd0; cmd_len = 9'd0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_read();
    test_ignore();
    test_two_byte();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
